// File: rtl/alu_mc_if.sv
// Handshake and data bundle between the EX-stage pipeline and the multi-cycle ALU.
interface alu_mc_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      alu_ctrl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;
    logic            zero;
    logic            busy;

    modport master (
        output flush, in_valid, a, b, alu_ctrl, out_ready,
        input  in_ready, out_valid, out, zero, busy
    );

    modport slave (
        input  flush, in_valid, a, b, alu_ctrl, out_ready,
        output in_ready, out_valid, out, zero, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle RV32I/M ALU: base ops finish in one cycle, mul/div/rem run a
// radix-2 iterative datapath over XLEN cycles on operand magnitudes.
module alu_mc #(
    parameter int XLEN   = 32,
    parameter bit MDU_EN = 1'b1
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   mcand;
    logic [SHW-1:0]    count;
    logic [2:0]        m_op;
    logic              neg;
    logic              div_zero;
    logic [XLEN-1:0]   out_r;
    logic              out_valid_r;
    logic              zero_r;
    logic              busy_r;

    logic              in_ready;
    logic              accept;
    logic              is_m;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   base_res;
    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              start_neg;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   acc_nx;
    logic [XLEN-1:0]   lo_nx;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   m_res;

    assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & bus.out_ready));
    assign accept   = bus.in_valid & in_ready & ~bus.flush;
    assign is_m     = (bus.alu_ctrl[4:3] == 2'b10) && MDU_EN;
    assign shamt    = bus.b[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (bus.alu_ctrl)
            5'b00000: base_res = bus.a + bus.b;
            5'b00001: base_res = bus.a - bus.b;
            5'b00010: base_res = bus.a << shamt;
            5'b00011: base_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            5'b00100: base_res = bus.a ^ bus.b;
            5'b00101: base_res = bus.a >> shamt;
            5'b00110: base_res = bus.a | bus.b;
            5'b00111: base_res = bus.a & bus.b;
            5'b01000: base_res = $signed(bus.a) >>> shamt;
            5'b01001: base_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            default:  base_res = '0;
        endcase
    end

    // Signedness per M op; the remainder takes the dividend's sign, everything else a^b.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (bus.alu_ctrl[2:0])
            3'b001, 3'b100, 3'b110: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'b010:  a_sgn = 1'b1;
            default: ;
        endcase
        a_neg     = a_sgn & bus.a[XLEN-1];
        b_neg     = b_sgn & bus.b[XLEN-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        start_neg = (bus.alu_ctrl[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
    end

    // acc/lo form the product (hi/lo) for multiply and remainder/quotient for divide.
    always_comb begin
        mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        div_diff = {acc, lo[XLEN-1]} - {1'b0, mcand};
        if (m_op[2]) begin
            if (!div_diff[XLEN]) begin
                acc_nx = div_diff[XLEN-1:0];
                lo_nx  = {lo[XLEN-2:0], 1'b1};
            end else begin
                acc_nx = {acc[XLEN-2:0], lo[XLEN-1]};
                lo_nx  = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nx = mul_sum[XLEN:1];
            lo_nx  = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod     = {acc_nx, lo_nx};
        prod_fix = neg ? -prod : prod;
        m_res    = '0;
        case (m_op)
            3'b000:                 m_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: m_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         m_res = div_zero ? '1 : (neg ? -lo_nx : lo_nx);
            default:                m_res = neg ? -acc_nx : acc_nx;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            lo          <= '0;
            mcand       <= '0;
            count       <= '0;
            m_op        <= '0;
            neg         <= 1'b0;
            div_zero    <= 1'b0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            zero_r      <= 1'b1;
            busy_r      <= 1'b0;
        end else if (bus.flush) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_m) begin
                            state       <= BUSY;
                            busy_r      <= 1'b1;
                            out_valid_r <= 1'b0;
                            count       <= '0;
                            m_op        <= bus.alu_ctrl[2:0];
                            neg         <= start_neg;
                            div_zero    <= (bus.b == '0);
                            acc         <= '0;
                            lo          <= bus.alu_ctrl[2] ? a_mag : b_mag;
                            mcand       <= bus.alu_ctrl[2] ? b_mag : a_mag;
                        end else begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            out_r       <= base_res;
                            zero_r      <= (base_res == '0);
                        end
                    end else if ((state == DONE) && bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    acc   <= acc_nx;
                    lo    <= lo_nx;
                    count <= count + 1'b1;
                    if (count == SHW'(XLEN-1)) begin
                        state       <= DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_r       <= m_res;
                        zero_r      <= (m_res == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.zero      = zero_r;
    assign bus.busy      = busy_r;
endmodule
